// File: rtl/quadram_pkg.sv
// Shared constants and types for the quadram burst controller.
// Bank select lives in the top address bits; the read buffer depth bounds outstanding reads.
package quadram_pkg;

    localparam int ADDR_WIDTH     = 11;
    localparam int RAM_ADDR_WIDTH = 9;
    localparam int BANK_MSB       = 10;
    localparam int BANK_LSB       = 9;
    localparam int RD_FIFO_DEPTH  = 4;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN,
        FIN
    } quadram_ctrl_state_t;

endpackage

// File: rtl/quadram_rd_fifo.sv
// Read-return buffer: push lands in the registered head one cycle later (valid/data are flops).
// No internal backpressure: the producer must never push into a full buffer; pop only counts when valid.
module quadram_rd_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = quadram_pkg::RD_FIFO_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             din_i,
    input  logic                         pop_i,
    output logic                         valid_o,
    output logic [WIDTH-1:0]             data_o,
    output logic [$clog2(DEPTH+1)-1:0]   occ_o
);
    import quadram_pkg::*;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    occ_q, occ_d, kept;
    logic             valid_q, do_pop;
    logic [WIDTH-1:0] data_q, data_d;

    assign do_pop  = pop_i & valid_q;
    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign occ_o   = occ_q;

    // The head register mirrors whichever entry will be oldest after this cycle.
    always_comb begin
        kept     = occ_q - CW'(do_pop);
        occ_d    = kept + CW'(push_i);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        data_d   = data_q;
        if (kept != '0) begin
            data_d = mem_q[rd_ptr_d];
        end else if (push_i) begin
            data_d = din_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            valid_q  <= (occ_d != '0);
            data_q   <= data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/quadram_ctrl.sv
// Burst initiator for quadram: writes hit the RAM in the wdata handshake cycle; reads return >=2 cycles after issue.
// Read issue stalls when buffer + in-flight reach 4 and inserts a bubble when the bank changes under a capture.
module quadram_ctrl #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  wdata_valid,
    output logic                  wdata_ready,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [3:0]            wstrb,
    output logic                  rdata_valid,
    input  logic                  rdata_ready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  done,
    output logic                  ram_en,
    output logic                  ram_wr,
    output logic [3:0]            ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);
    import quadram_pkg::*;

    localparam int OCC_W = $clog2(RD_FIFO_DEPTH + 1);

    quadram_ctrl_state_t   state_q;
    logic [ADDR_WIDTH-1:0] addr_q, last_addr_q;
    logic [DATA_WIDTH-1:0] last_din_q;
    logic [LEN_WIDTH-1:0]  rem_q, ret_q;
    logic                  inflight_q, done_q, cmd_ready_q, wdata_ready_q;
    logic [OCC_W-1:0]      occ;
    logic                  rd_pop, wr_acc, rd_acc, room, bank_bubble;

    assign cmd_ready   = cmd_ready_q;
    assign wdata_ready = wdata_ready_q;
    assign done        = done_q;
    assign rd_pop      = rdata_valid & rdata_ready;

    assign wr_acc      = wdata_ready_q & wdata_valid;
    assign room        = (int'(occ) + int'(inflight_q)) < RD_FIFO_DEPTH;
    // The RAM output mux follows the live address, so a capture must see its own bank.
    assign bank_bubble = inflight_q &&
                         (addr_q[BANK_MSB:BANK_LSB] != last_addr_q[BANK_MSB:BANK_LSB]);
    assign rd_acc      = (state_q == READ) && room && !bank_bubble;

    assign ram_en   = wr_acc | rd_acc;
    assign ram_wr   = wr_acc;
    assign ram_we   = wr_acc ? wstrb : 4'b0000;
    assign ram_addr = (wr_acc | rd_acc) ? addr_q : last_addr_q;
    assign ram_din  = wr_acc ? wdata : last_din_q;

    quadram_rd_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (RD_FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (inflight_q),
        .din_i   (ram_dout),
        .pop_i   (rd_pop),
        .valid_o (rdata_valid),
        .data_o  (rdata),
        .occ_o   (occ)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            last_addr_q   <= '0;
            last_din_q    <= '0;
            rem_q         <= '0;
            ret_q         <= '0;
            inflight_q    <= 1'b0;
            done_q        <= 1'b0;
            cmd_ready_q   <= 1'b1;
            wdata_ready_q <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            inflight_q <= rd_acc;
            if (wr_acc | rd_acc) begin
                last_addr_q <= addr_q;
                addr_q      <= addr_q + 1'b1;
                rem_q       <= rem_q - 1'b1;
            end
            if (wr_acc) begin
                last_din_q <= wdata;
            end
            if (rd_pop) begin
                ret_q <= ret_q - 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        addr_q      <= cmd_addr;
                        rem_q       <= cmd_len;
                        ret_q       <= cmd_len;
                        cmd_ready_q <= 1'b0;
                        if (cmd_len == '0) begin
                            state_q <= FIN;
                            done_q  <= 1'b1;
                        end else if (cmd_write) begin
                            state_q       <= WRITE;
                            wdata_ready_q <= 1'b1;
                        end else begin
                            state_q <= READ;
                        end
                    end
                end
                WRITE: begin
                    if (wr_acc && rem_q == LEN_WIDTH'(1)) begin
                        state_q       <= FIN;
                        done_q        <= 1'b1;
                        wdata_ready_q <= 1'b0;
                    end
                end
                READ: begin
                    if (rd_acc && rem_q == LEN_WIDTH'(1)) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (rd_pop && ret_q == LEN_WIDTH'(1)) begin
                        state_q <= FIN;
                        done_q  <= 1'b1;
                    end
                end
                FIN: begin
                    state_q     <= IDLE;
                    cmd_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= IDLE;
                    cmd_ready_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_quadram_ctrl.sv
// Directed bench for quadram_ctrl with a behavioural 4-bank quadram whose output mux follows the live address.
module tb_quadram_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [10:0] cmd_addr;
    logic [11:0] cmd_len;
    logic        wdata_valid, wdata_ready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        rdata_valid, rdata_ready;
    logic [31:0] rdata;
    logic        done;
    logic        ram_en, ram_wr;
    logic [3:0]  ram_we;
    logic [10:0] ram_addr;
    logic [31:0] ram_din, ram_dout;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    quadram_ctrl #(.ADDR_WIDTH(11), .DATA_WIDTH(32), .LEN_WIDTH(12)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .wdata_valid (wdata_valid),
        .wdata_ready (wdata_ready),
        .wdata       (wdata),
        .wstrb       (wstrb),
        .rdata_valid (rdata_valid),
        .rdata_ready (rdata_ready),
        .rdata       (rdata),
        .done        (done),
        .ram_en      (ram_en),
        .ram_wr      (ram_wr),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_din     (ram_din),
        .ram_dout    (ram_dout)
    );

    // Quadram model: each bank has its own output register; the live address picks the bank.
    logic        preload;
    logic [31:0] mem [2048];
    logic [31:0] bank_out [4];

    function automatic logic [31:0] pat(input int a);
        return 32'hC0DE_0000 | 32'(a);
    endfunction

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 2048; i++) mem[i] <= pat(i);
        end else if (ram_en) begin
            if (ram_wr) begin
                for (int b = 0; b < 4; b++)
                    if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
            end else begin
                bank_out[ram_addr[10:9]] <= mem[ram_addr];
            end
        end
    end
    assign ram_dout = bank_out[ram_addr[10:9]];

    // Passive monitors: cycle counter, RAM trace, read log, done/en counters, hold stability.
    int          cyc_cnt = 0;
    int          done_cnt = 0, en_cnt = 0, rd_cnt = 0, stab_err = 0;
    int          hs_cyc = 0, done_cyc = 0, max_occ = 0;
    logic        trace_en [4096];
    logic [10:0] trace_addr [4096];
    logic [31:0] rd_log [256];
    logic        pv = 1'b0, pr = 1'b0;
    logic [31:0] pd = '0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    always @(negedge clk) begin
        trace_en[cyc_cnt[11:0]]   <= ram_en;
        trace_addr[cyc_cnt[11:0]] <= ram_addr;
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc_cnt;
        end
        if (ram_en) en_cnt <= en_cnt + 1;
        if (rdata_valid && rdata_ready) begin
            rd_log[rd_cnt[7:0]] <= rdata;
            rd_cnt <= rd_cnt + 1;
            hs_cyc <= cyc_cnt;
        end
        if (int'(dut.u_fifo.occ_q) > max_occ) max_occ <= int'(dut.u_fifo.occ_q);
        if (rst_n && pv && !pr && !(rdata_valid && rdata == pd)) stab_err <= stab_err + 1;
        pv <= rdata_valid;
        pr <= rdata_ready;
        pd <= rdata;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic wr, input logic [10:0] a, input logic [11:0] len);
        int t = 0;
        while (!cmd_ready && t < 100) begin
            step();
            t++;
        end
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_len   = len;
        #1;
        chk("no_ram_in_cmd_cycle", 32'(ram_en), 32'd0);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic write1(input logic [10:0] a, input logic [31:0] d, input logic [3:0] s);
        send_cmd(1'b1, a, 12'd1);
        wdata_valid = 1'b1;
        wdata = d;
        wstrb = s;
        step();
        wdata_valid = 1'b0;
        chk("w1_done", 32'(done), 32'd1);
        step();
    endtask

    task automatic read_burst(input logic [10:0] a, input logic [11:0] len, input bit toggle,
                              output int r0, output int c0);
        int t = 0;
        int dn;
        dn = done_cnt;
        r0 = rd_cnt;
        rdata_ready = 1'b1;
        send_cmd(1'b0, a, len);
        c0 = cyc_cnt;
        while (done_cnt == dn && t < 500) begin
            if (toggle) rdata_ready = ~rdata_ready;
            step();
            t++;
        end
        rdata_ready = 1'b1;
        chk("rd_done_once", 32'(done_cnt - dn), 32'd1);
        chk("rd_count", 32'(rd_cnt - r0), 32'(len));
        chk("rd_done_after_last_hs", 32'(done_cyc - hs_cyc), 32'd1);
    endtask

    initial begin
        int r0, c0, e0, dn;

        rst_n = 1'b0;
        preload = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wdata_valid = 1'b0; wdata = '0; wstrb = '0;
        rdata_ready = 1'b1;
        step(); step(); step();

        // Reset state
        chk("rst_cmd_ready",   32'(cmd_ready),   32'd1);
        chk("rst_wdata_ready", 32'(wdata_ready), 32'd0);
        chk("rst_rdata_valid", 32'(rdata_valid), 32'd0);
        chk("rst_done",        32'(done),        32'd0);
        chk("rst_ram_en",      32'(ram_en),      32'd0);
        chk("rst_ram_wr",      32'(ram_wr),      32'd0);
        chk("rst_ram_we",      32'(ram_we),      32'd0);
        chk("rst_ram_addr",    32'(ram_addr),    32'd0);
        chk("rst_ram_din",     ram_din,          32'd0);
        preload = 1'b0;
        rst_n = 1'b1;
        step();

        // Write burst 0x010 len 4, one word per cycle
        send_cmd(1'b1, 11'h010, 12'd4);
        for (int i = 0; i < 4; i++) begin
            wdata_valid = 1'b1;
            wdata = 32'hA0 + 32'(i);
            wstrb = 4'hF;
            #1;
            chk("wr_ready", 32'(wdata_ready), 32'd1);
            chk("wr_en",    32'(ram_en),      32'd1);
            chk("wr_wr",    32'(ram_wr),      32'd1);
            chk("wr_addr",  32'(ram_addr),    32'h10 + 32'(i));
            chk("wr_din",   ram_din,          32'hA0 + 32'(i));
            chk("wr_we",    32'(ram_we),      32'hF);
            step();
        end
        wdata_valid = 1'b0;
        chk("wr_done",   32'(done),   32'd1);
        chk("wr_fin_en", 32'(ram_en), 32'd0);
        step();
        chk("wr_cmd_ready_again", 32'(cmd_ready), 32'd1);

        // Read back
        read_burst(11'h010, 12'd4, 1'b0, r0, c0);
        for (int i = 0; i < 4; i++) chk("rb_data", rd_log[r0 + i], 32'hA0 + 32'(i));

        // Bank-crossing read with expected issue trace
        read_burst(11'h1FE, 12'd4, 1'b0, r0, c0);
        chk("bx_en0",   32'(trace_en[c0[11:0]]),       32'd1);
        chk("bx_a0",    32'(trace_addr[c0[11:0]]),     32'h1FE);
        chk("bx_en1",   32'(trace_en[(c0+1) % 4096]),  32'd1);
        chk("bx_a1",    32'(trace_addr[(c0+1) % 4096]), 32'h1FF);
        chk("bx_en2",   32'(trace_en[(c0+2) % 4096]),  32'd0);
        chk("bx_a2",    32'(trace_addr[(c0+2) % 4096]), 32'h1FF);
        chk("bx_en3",   32'(trace_en[(c0+3) % 4096]),  32'd1);
        chk("bx_a3",    32'(trace_addr[(c0+3) % 4096]), 32'h200);
        chk("bx_en4",   32'(trace_en[(c0+4) % 4096]),  32'd1);
        chk("bx_a4",    32'(trace_addr[(c0+4) % 4096]), 32'h201);
        for (int i = 0; i < 4; i++) chk("bx_data", rd_log[r0 + i], pat(32'h1FE + i));

        // Wrap-around 0x7FF -> 0x000 with one bubble
        read_burst(11'h7FF, 12'd2, 1'b0, r0, c0);
        chk("wrap_en0", 32'(trace_en[c0[11:0]]),        32'd1);
        chk("wrap_a0",  32'(trace_addr[c0[11:0]]),      32'h7FF);
        chk("wrap_en1", 32'(trace_en[(c0+1) % 4096]),   32'd0);
        chk("wrap_en2", 32'(trace_en[(c0+2) % 4096]),   32'd1);
        chk("wrap_a2",  32'(trace_addr[(c0+2) % 4096]), 32'h000);
        chk("wrap_d0",  rd_log[r0],     pat(32'h7FF));
        chk("wrap_d1",  rd_log[r0 + 1], pat(0));

        // Partial write via byte strobes
        write1(11'h100, 32'h1234_5678, 4'hF);
        write1(11'h100, 32'hFFFF_FFFF, 4'h3);
        read_burst(11'h100, 12'd1, 1'b0, r0, c0);
        chk("pw_data", rd_log[r0], 32'h1234_FFFF);

        // Backpressure: rdata_ready toggling every cycle
        read_burst(11'h300, 12'd16, 1'b1, r0, c0);
        for (int i = 0; i < 16; i++) chk("bp_data", rd_log[r0 + i], pat(32'h300 + i));
        chk("bp_max_occ_le4", 32'(max_occ <= 4), 32'd1);
        chk("bp_hold_stable", 32'(stab_err), 32'd0);

        // Zero-length command: done next cycle, no RAM access
        e0 = en_cnt;
        send_cmd(1'b0, 11'h055, 12'd0);
        chk("z_done", 32'(done), 32'd1);
        step();
        chk("z_done_clear",  32'(done),      32'd0);
        chk("z_cmd_ready",   32'(cmd_ready), 32'd1);
        chk("z_no_ram_en",   32'(en_cnt - e0), 32'd0);

        // Reset pulsed during a len-8 read with the sink stalled
        rdata_ready = 1'b0;
        send_cmd(1'b0, 11'h020, 12'd8);
        rdata_ready = 1'b0;
        repeat (5) step();
        chk("mr_buffer_valid", 32'(rdata_valid), 32'd1);
        dn = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("mr_rdata_valid", 32'(rdata_valid), 32'd0);
        chk("mr_cmd_ready",   32'(cmd_ready),   32'd1);
        chk("mr_ram_en",      32'(ram_en),      32'd0);
        step(); step();
        rst_n = 1'b1;
        rdata_ready = 1'b1;
        repeat (10) step();
        chk("mr_no_done",     32'(done_cnt - dn), 32'd0);
        chk("mr_still_empty", 32'(rdata_valid),   32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/quadram_ctrl.md
# quadram_ctrl

Burst initiator that drives the quadram 2048×32 memory on behalf of the subdivision datapath. It accepts a command (write or read, base word address, word count). It streams write data from a valid/ready source into the memory, or streams read data out to a valid/ready sink. It hides the quadram's one-cycle read latency and its address-dependent output mux behind a 4-entry read buffer, and pulses `done` when the burst finishes.

## Interface
- `ADDR_WIDTH`, 11: word address width; matches quadram, top 2 bits select the bank.
- `DATA_WIDTH`, 32: data word width.
- `LEN_WIDTH`, 12: burst length width; 0..2048 words.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid` / `cmd_ready`  in/out  1  command handshake; `cmd_ready` is high only in IDLE.
- `cmd_write`  in  1  1 = write burst, 0 = read burst.
- `cmd_addr`  in  ADDR_WIDTH  first word address.
- `cmd_len`  in  LEN_WIDTH  word count.
- `wdata_valid` / `wdata_ready`  in/out  1  write-data handshake.
- `wdata`  in  DATA_WIDTH  write word.
- `wstrb`  in  4  byte enables for the write word.
- `rdata_valid` / `rdata_ready`  out/in  1  read-data handshake.
- `rdata`  out  DATA_WIDTH  read word.
- `done`  out  1  one-cycle pulse at burst completion.
- `ram_en`, `ram_wr`  out  1  quadram `en` and `wr`.
- `ram_we`  out  4  quadram `we`.
- `ram_addr`  out  ADDR_WIDTH  quadram address.
- `ram_din`  out  DATA_WIDTH  quadram write data.
- `ram_dout`  in  DATA_WIDTH  quadram read data.

## Operation
- **States.**
  - IDLE → WRITE on a command handshake with `cmd_write`=1 and `cmd_len`≠0.
  - IDLE → READ on a command handshake with `cmd_write`=0 and `cmd_len`≠0.
  - IDLE → FIN when `cmd_len`=0; no RAM access occurs.
  - WRITE → FIN when the last write data is accepted.
  - READ → DRAIN when the last read is issued.
  - DRAIN → FIN when the last `rdata` handshake occurs.
  - FIN → IDLE after one cycle; `done`=1 in FIN.
- **WRITE.**
  - `wdata_ready`=1 throughout WRITE.
  - On each `wdata` handshake, drive in the same cycle: `ram_en`=1, `ram_wr`=1, `ram_we`=`wstrb`, `ram_din`=`wdata`, `ram_addr`=current address.
  - After each handshake, the address increments and the remaining count decrements.
- **READ issue.**
  - Issue condition: `occ + inflight < 4`, where `occ` is the buffer occupancy and `inflight` (0/1) marks a read issued in the previous cycle. On issue: `ram_en`=1, `ram_wr`=0, `ram_we`=0.
  - `ram_dout` is captured into the buffer in the cycle after an issue.
- **Bank-crossing bubble.**
  - The quadram output mux follows the live address, so during a capture cycle `ram_addr[10:9]` must equal the bank of the captured read.
  - If the next issue address lies in a different bank, that cycle issues nothing: `ram_en`=0 and `ram_addr` holds the previous address.
- **Address arithmetic.** Addresses are modulo 2^ADDR_WIDTH; 0x7FF+1 = 0x000 (this is also a bank change and incurs the bubble).
- **Idle RAM drive.** In all non-issuing cycles: `ram_en`=0, `ram_wr`=0, `ram_we`=0; `ram_din` and `ram_addr` hold their last values.
- **Command handling.** Commands are ignored outside IDLE. Write data presented outside WRITE is not accepted.

## Timing
- **Reset values.** State=IDLE, `occ`=0, `inflight`=0, `rdata_valid`=0, `done`=0, `ram_en`=0, `ram_wr`=0, `ram_we`=0, `ram_addr`=0, `ram_din`=0. Consequently `cmd_ready`=1 and `wdata_ready`=0.
- **First RAM access.** A command handshake in cycle t gives the first RAM access no earlier than t+1.
- **Read latency.** An issue in cycle t is captured at the end of t+1. `rdata_valid` rises in t+2 at the earliest.
- **Throughput.** With `rdata_ready` held high, reads sustain 1 word/cycle except at bank-crossing bubbles. Writes sustain 1 word/cycle.
- **Read buffer.** The buffer never overflows. `rdata` and `rdata_valid` are registered outputs. `rdata` holds stable while `rdata_valid`=1 and `rdata_ready`=0.
- **Completion.** `done` asserts the cycle after the final write handshake or final `rdata` handshake. `cmd_ready`=1 again the following cycle.
- **Mid-burst reset.** Asserting `rst_n` low mid-burst returns all state and outputs to reset values immediately. Buffered data is discarded and no `done` is issued.

## Structure
- Package `quadram_pkg`:
  - `ADDR_WIDTH`, `RAM_ADDR_WIDTH` (9), `BANK_MSB`/`BANK_LSB` (10/9).
  - `RD_FIFO_DEPTH` (4).
  - `quadram_ctrl_state_t` enum {IDLE, WRITE, READ, DRAIN, FIN}.
- Sub-module `quadram_rd_fifo`: 4×32 synchronous FIFO with `push`, `pop`, registered `valid`/`data` and an `occ` output. It does not instantiate the quadram.

## Test plan
- **Write then read back.** Write burst at 0x010 with len 4, data 0xA0..0xA3, `wstrb`=0xF; then read burst at 0x010 with len 4. Required: `rdata` 0xA0..0xA3 in order and `done` after each burst.
- **Bank-crossing read.** Read 0x1FE with len 4 over preloaded data. Required: `ram_addr` sequence 0x1FE, 0x1FF, 0x1FF (with `ram_en`=0), 0x200, 0x201; data returned in correct order.
- **Wrap-around.** Read 0x7FF with len 2. Required: words come from 0x7FF and then 0x000, with one bubble between the two issues.
- **Partial write.** Word 0x12345678 at 0x100, then write 0xFFFFFFFF with `wstrb`=0x3. Required: read returns 0x1234FFFF.
- **Backpressure.** Read of len 16 with `rdata_ready` toggling 1/0 every cycle. Required: all 16 words appear exactly once, `occ` never exceeds 4, and `done` appears after the 16th handshake.
- **Zero length and mid-burst reset.**
  - `cmd_len`=0: required `done` in t+1 and `ram_en` never asserted.
  - Reset pulsed during a len-8 read: required `rdata_valid`=0 and `cmd_ready`=1 immediately, and no `done` pulse.
